// File: rtl/parity_step_counter_if.sv
// parity_step_counter_if: control/data bundle for parity_step_counter
//   i_en/i_ld/i_d/i_mode are driven by the master; o_q/o_wrap/o_aligned by the counter
interface parity_step_counter_if #(parameter int WIDTH = 3);
  logic             i_en;
  logic             i_ld;
  logic [WIDTH-1:0] i_d;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] o_q;
  logic             o_wrap;
  logic             o_aligned;
  modport master (output i_en, i_ld, i_d, i_mode, input o_q, o_wrap, o_aligned);
  modport slave (input i_en, i_ld, i_d, i_mode, output o_q, o_wrap, o_aligned);
endinterface

// File: rtl/parity_step_counter.sv
// parity_step_counter: falling-edge up/down parity counter (even-up, odd-down, binary up/down)
//   clk: clock, state changes on the falling edge; rst: asynchronous active-low reset
//   bus.i_en: count enable; bus.i_ld: parallel load (wins over i_en); bus.i_d: load value
//   bus.i_mode: 00 odd down, 01 even up, 10 binary up, 11 binary down
//   bus.o_q: count; bus.o_wrap: one-cycle carry/borrow pulse; bus.o_aligned: parity legal for mode
module parity_step_counter #(parameter int WIDTH = 3) (
  input logic                 clk,
  input logic                 rst,
  parity_step_counter_if.slave bus
);
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             w_up;
  logic             w_two;
  logic [WIDTH:0]   w_step;
  logic [WIDTH:0]   w_next;
  assign w_up = bus.i_mode[1] ^ bus.i_mode[0];
  // A parity mode takes a full step of 2 only once Q already has the mode's parity
  assign w_two = !bus.i_mode[1] && (r_q[0] != bus.i_mode[0]);
  assign w_step = {{(WIDTH-1){1'b0}}, w_two, !w_two};
  // The extra top bit is the carry (up) or borrow (down) that flags a wrap
  assign w_next = w_up ? {1'b0, r_q} + w_step : {1'b0, r_q} - w_step;
  always_ff @(negedge clk or negedge rst)
    if (!rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else if (bus.i_ld) begin
      r_q    <= bus.i_d;
      r_wrap <= 1'b0;
    end else if (bus.i_en) begin
      r_q    <= w_next[WIDTH-1:0];
      r_wrap <= w_next[WIDTH];
    end else
      r_wrap <= 1'b0;
  assign bus.o_q       = r_q;
  assign bus.o_wrap    = r_wrap;
  assign bus.o_aligned = bus.i_mode[1] | (r_q[0] != bus.i_mode[0]);
endmodule

// File: tb/tb_parity_step_counter.sv
// tb_parity_step_counter: drives WIDTH=2,3,4,8 counters in parallel against an arithmetic model
module tb_parity_step_counter;
  localparam int W_A [4] = '{2, 3, 4, 8};
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        ld = 1'b0;
  logic [15:0] d = '0;
  logic [1:0]  mode = 2'b01;
  logic [15:0] q_a [4];
  logic        wrap_a [4];
  logic        al_a [4];
  int          m_q [4] = '{default: 0};
  bit          m_w [4] = '{default: 0};
  int          n_chk = 0;
  int          n_pass = 0;
  bit          run = 1'b0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : u
    localparam int W = W_A[g];
    parity_step_counter_if #(.WIDTH(W)) ifc ();
    parity_step_counter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
    assign ifc.i_en   = en;
    assign ifc.i_ld   = ld;
    assign ifc.i_d    = d[W-1:0];
    assign ifc.i_mode = mode;
    assign q_a[g]     = 16'(ifc.o_q);
    assign wrap_a[g]  = ifc.o_wrap;
    assign al_a[g]    = ifc.o_aligned;
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk or negedge rst) begin
    int n, v;
    for (int k = 0; k < 4; k++) begin
      n = 1 << W_A[k];
      v = 0;
      if (!rst) begin
        m_q[k] = 0;
        m_w[k] = 0;
      end else if (ld) begin
        m_q[k] = int'(d) % n;
        m_w[k] = 0;
      end else if (!en) begin
        m_w[k] = 0;
      end else begin
        case (mode)
          2'b01:   v = m_q[k] + ((m_q[k] % 2 == 0) ? 2 : 1);
          2'b00:   v = m_q[k] - ((m_q[k] % 2 == 1) ? 2 : 1);
          2'b10:   v = m_q[k] + 1;
          default: v = m_q[k] - 1;
        endcase
        m_w[k] = (v >= n) || (v < 0);
        m_q[k] = (v + n) % n;
      end
    end
  end
  always @(posedge clk)
    if (run)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("model_q_w%0d", W_A[k]), int'(q_a[k]), m_q[k]);
        chk($sformatf("model_wrap_w%0d", W_A[k]), int'(wrap_a[k]), int'(m_w[k]));
        chk($sformatf("model_aligned_w%0d", W_A[k]), int'(al_a[k]),
            mode == 2'b00 ? m_q[k] % 2 : mode == 2'b01 ? 1 - m_q[k] % 2 : 1);
      end
  initial begin
    int e1 [4] = '{2, 4, 6, 0};
    int w1 [4] = '{0, 0, 0, 1};
    int e2 [5] = '{7, 5, 3, 1, 7};
    int w2 [5] = '{1, 0, 0, 0, 1};
    int wc [4] = '{default: 0};
    int wq [4] = '{default: -1};
    #1 rst = 1'b0;
    cyc();
    cyc();
    run = 1'b1;
    chk("reset_q", int'(q_a[1]), 0);
    chk("reset_wrap", int'(wrap_a[1]), 0);
    rst = 1'b1;
    ld = 1'b1;
    d = 16'd5;
    cyc();
    ld = 1'b0;
    chk("load5_q", int'(q_a[1]), 5);
    rst = 1'b0;
    #1;
    chk("async_reset_q", int'(q_a[1]), 0);
    chk("async_reset_wrap", int'(wrap_a[1]), 0);
    cyc();
    rst = 1'b1;
    mode = 2'b01;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("even_up_q%0d", i), int'(q_a[1]), e1[i]);
      chk($sformatf("even_up_wrap%0d", i), int'(wrap_a[1]), w1[i]);
      chk($sformatf("even_up_aligned%0d", i), int'(al_a[1]), 1);
    end
    rst = 1'b0;
    mode = 2'b00;
    cyc();
    chk("odd_down_aligned_at0", int'(al_a[1]), 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("odd_down_q%0d", i), int'(q_a[1]), e2[i]);
      chk($sformatf("odd_down_wrap%0d", i), int'(wrap_a[1]), w2[i]);
      chk($sformatf("odd_down_aligned%0d", i), int'(al_a[1]), 1);
    end
    ld = 1'b1;
    d = 16'd4;
    cyc();
    ld = 1'b0;
    chk("switch_load4_q", int'(q_a[1]), 4);
    chk("switch_load4_aligned", int'(al_a[1]), 0);
    cyc();
    chk("switch_q3", int'(q_a[1]), 3);
    chk("switch_q3_aligned", int'(al_a[1]), 1);
    cyc();
    chk("switch_q1", int'(q_a[1]), 1);
    mode = 2'b01;
    cyc();
    chk("switch_q2", int'(q_a[1]), 2);
    cyc();
    chk("switch_q4", int'(q_a[1]), 4);
    ld = 1'b1;
    d = 16'd7;
    cyc();
    ld = 1'b0;
    chk("switch_load7_q", int'(q_a[1]), 7);
    chk("switch_load7_aligned", int'(al_a[1]), 0);
    cyc();
    chk("switch_align_wrap_q", int'(q_a[1]), 0);
    chk("switch_align_wrap", int'(wrap_a[1]), 1);
    ld = 1'b1;
    d = 16'd5;
    cyc();
    chk("ld_priority_q", int'(q_a[1]), 5);
    chk("ld_priority_wrap", int'(wrap_a[1]), 0);
    ld = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("hold_q%0d", i), int'(q_a[1]), 5);
      chk($sformatf("hold_wrap%0d", i), int'(wrap_a[1]), 0);
    end
    mode = 2'b10;
    en = 1'b1;
    ld = 1'b1;
    d = 16'd14;
    cyc();
    ld = 1'b0;
    chk("bin_up_load_q", int'(q_a[2]), 14);
    cyc();
    chk("bin_up_q15", int'(q_a[2]), 15);
    chk("bin_up_q15_wrap", int'(wrap_a[2]), 0);
    cyc();
    chk("bin_up_q0", int'(q_a[2]), 0);
    chk("bin_up_q0_wrap", int'(wrap_a[2]), 1);
    chk("bin_up_aligned", int'(al_a[2]), 1);
    cyc();
    chk("bin_up_q1", int'(q_a[2]), 1);
    chk("bin_up_q1_wrap", int'(wrap_a[2]), 0);
    mode = 2'b11;
    ld = 1'b1;
    d = 16'd1;
    cyc();
    ld = 1'b0;
    chk("bin_down_load_q", int'(q_a[2]), 1);
    cyc();
    chk("bin_down_q0", int'(q_a[2]), 0);
    chk("bin_down_q0_wrap", int'(wrap_a[2]), 0);
    cyc();
    chk("bin_down_q15", int'(q_a[2]), 15);
    chk("bin_down_q15_wrap", int'(wrap_a[2]), 1);
    chk("bin_down_aligned", int'(al_a[2]), 1);
    cyc();
    chk("bin_down_q14", int'(q_a[2]), 14);
    chk("bin_down_q14_wrap", int'(wrap_a[2]), 0);
    rst = 1'b0;
    mode = 2'b01;
    cyc();
    rst = 1'b1;
    for (int s = 1; s <= 129; s++) begin
      cyc();
      for (int k = 0; k < 4; k++)
        if (s <= (1 << (W_A[k] - 1)) + 1 && wrap_a[k]) begin
          wc[k]++;
          wq[k] = int'(q_a[k]);
        end
    end
    chk("sweep_w2_wraps", wc[0], 1);
    chk("sweep_w2_wrap_q", wq[0], 0);
    chk("sweep_w8_wraps", wc[3], 1);
    chk("sweep_w8_wrap_q", wq[3], 0);
    cyc();
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/parity_step_counter.md
# parity_step_counter

Parametrised up/down parity counter: each active clock step moves the count through even values ascending, odd values descending, or plain binary up/down, selected by a 2-bit mode. It generalises the lab's 3-bit even-up/odd-down counter to any width. It adds parallel load, count enable, a wrap pulse and a parity-aligned flag. It sits in the lab counter/display path and feeds 7-segment decode and sequence-check logic.

## Interface
- WIDTH, 3, count width in bits; legal range 2..16
- clk  in  1  clock; all state changes on the falling edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  count enable; sampled on the falling edge of clk
- ld  in  1  synchronous parallel load; priority over en
- d  in  WIDTH  load value
- mode  in  2  count mode:
  - 00: odd descending
  - 01: even ascending
  - 10: binary up
  - 11: binary down
- Q  out  WIDTH  count value (registered)
- wrap  out  1  registered pulse; high for the one cycle in which Q holds a value produced by an overflow or underflow
- aligned  out  1  combinational; high when Q parity is legal for the current mode

## Operation
- Reset: rst=0 forces Q=0 and wrap=0 immediately, independent of clk. Both hold while rst=0.
- Priority at each falling edge: ld, then en, then hold.
- ld=1: Q<=d verbatim, with no alignment. wrap<=0.
- ld=0, en=0: Q holds and wrap<=0.
- ld=0, en=1, next Q by mode (all arithmetic modulo 2^WIDTH, N = 2^WIDTH):
  - Mode 01, Q even: Q+2.
  - Mode 01, Q odd: Q+1 (alignment step).
  - Mode 00, Q odd: Q-2.
  - Mode 00, Q even: Q-1 (alignment step).
  - Mode 10: Q+1.
  - Mode 11: Q-1.
- wrap<=1 exactly when the addition carries out of WIDTH bits (up modes) or the subtraction borrows (down modes). Otherwise wrap<=0.
- Wrap cases:
  - Mode 01: N-2 to 0, and the alignment step N-1 to 0, both assert wrap.
  - Mode 00: 1 to N-1, and the alignment step 0 to N-1, both assert wrap.
  - Mode 10: N-1 to 0.
  - Mode 11: 0 to N-1.
- aligned:
  - mode 00: Q[0]==1.
  - mode 01: Q[0]==0.
  - modes 10/11: always 1.
- A mode change takes effect at the next active edge. The first step after switching between 00 and 01 is always an alignment step. This matches the legacy 3-bit counter behaviour for the same sequence.
- Steady-state sequences:
  - Mode 01: 0,2,…,N-2,0.
  - Mode 00: N-1,N-3,…,1,N-1.

## Timing
- Latency: Q and wrap update one falling edge after en/ld/mode/d are sampled. There is no pipeline.
- aligned follows Q and mode combinationally within the same cycle.
- rst assertion is asynchronous. Deassertion must meet recovery/removal timing to the falling edge of clk. The first count step is at the first falling edge after deassertion with en=1.
- A reset asserted mid-sequence clears Q and a pending wrap in the same cycle.
- If ld=1 and en=1 on the same edge, the load wins and no step occurs.

## Test plan
- Reset: WIDTH=3, drive rst=0 asynchronously mid-cycle with Q=5 → Q=0 and wrap=0 before the next edge. Release, mode=01, en=1 → Q=2,4,6,0 with wrap=1 only on the cycle Q=0; aligned=1 throughout.
- Odd descending from reset: WIDTH=3, mode=00, en=1 from Q=0 → Q=7 (wrap=1, alignment step), then 5,3,1,7 with wrap=1 at the second 7. aligned=0 only while Q=0.
- Mode switch and alignment: WIDTH=3, load d=4, mode=00 → Q=3 (aligned=1), 1. Switch to mode=01 → Q=2, 4. Load d=7 with mode=01 → aligned=0, next Q=0 with wrap=1.
- Load and enable priority: ld=1, en=1, d=5 → Q=5, wrap=0. Then ld=0, en=0 for 3 cycles → Q stays 5.
- Binary modes, WIDTH=4:
  - Mode 10 from d=14 → 15, 0 (wrap=1), 1.
  - Mode 11 from 1 → 0, 15 (wrap=1), 14.
  - aligned=1 throughout.
- Width sweep: WIDTH=2 and WIDTH=8, mode=01 from 0 for 2^(WIDTH-1)+1 steps → exactly one wrap pulse, coinciding with Q returning to 0.
